// File: rtl/frame_decimator.sv
// Frame decimator: passes one sensor frame in every (iSKIP+1), either continuously or single-shot.
// Optional capture counter on oCap_Cnt enabled by defining FRAME_DECIM_STATS_EN.
module frame_decimator #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             iFVAL,
   input  logic             iDVAL,
   input  logic             iEN,
   input  logic             iMODE,
   input  logic [CNT_W-1:0] iSKIP,
   output logic             oFrame_En,
   output logic             oDVAL,
   output logic             oFrame_Start,
   output logic             oFrame_Done,
   output logic             oBusy,
   output logic [15:0]      oCap_Cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StSync,
      StArm,
      StCapture,
      StHold
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_fval;
   logic [CNT_W-1:0] r_skip_cnt;
   logic [CNT_W-1:0] r_skip_lat;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_lat_nxt;
   logic             r_frame_en;
   logic             r_dval;
   logic             r_start;
   logic             r_done;
   logic             w_en_nxt;
   logic             w_start_nxt;
   logic             w_done_nxt;
   logic             w_rise;
   logic             w_fall;
   logic             w_hit;
   logic             w_sel;

   assign w_rise = iFVAL & ~r_fval;
   assign w_fall = ~iFVAL & r_fval;
   assign w_hit  = (r_skip_cnt == r_skip_lat);
   assign w_sel  = (r_state == StCapture) | ((r_state == StArm) & w_rise & w_hit);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_skip_cnt;
      w_lat_nxt   = r_skip_lat;
      w_en_nxt    = r_frame_en;
      w_start_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (iEN) w_state_nxt = StSync;
         end
         StSync: begin
            if (!iEN) begin
               w_state_nxt = StIdle;
            end else if (!iFVAL) begin
               // Wait for a frame gap so capture never begins mid-frame.
               w_state_nxt = StArm;
               w_cnt_nxt   = '0;
               w_lat_nxt   = iSKIP;
            end
         end
         StArm: begin
            if (!iEN) begin
               w_state_nxt = StIdle;
            end else if (w_rise) begin
               if (w_hit) begin
                  w_state_nxt = StCapture;
                  w_en_nxt    = 1'b1;
                  w_start_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_skip_cnt + 1'b1;
               end
            end
         end
         StCapture: begin
            if (w_fall) begin
               w_en_nxt   = 1'b0;
               w_done_nxt = 1'b1;
               w_cnt_nxt  = '0;
               w_lat_nxt  = iSKIP;
               if (iMODE)     w_state_nxt = StHold;
               else if (!iEN) w_state_nxt = StIdle;
               else           w_state_nxt = StArm;
            end
         end
         StHold: begin
            if (!iEN) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_state    <= StIdle;
         r_fval     <= 1'b0;
         r_skip_cnt <= '0;
         r_skip_lat <= '0;
         r_frame_en <= 1'b0;
         r_dval     <= 1'b0;
         r_start    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fval     <= iFVAL;
         r_skip_cnt <= w_cnt_nxt;
         r_skip_lat <= w_lat_nxt;
         r_frame_en <= w_en_nxt;
         r_dval     <= iDVAL & iFVAL & w_sel;
         r_start    <= w_start_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign oFrame_En    = r_frame_en;
   assign oDVAL        = r_dval;
   assign oFrame_Start = r_start;
   assign oFrame_Done  = r_done;
   assign oBusy        = (r_state != StIdle);

`ifdef FRAME_DECIM_STATS_EN
   logic [15:0] r_cap_cnt;

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         r_cap_cnt <= '0;
      end else if (w_done_nxt) begin
         r_cap_cnt <= r_cap_cnt + 16'd1;
      end
   end

   assign oCap_Cnt = r_cap_cnt;
`else
   assign oCap_Cnt = '0;
`endif

endmodule

// File: tb/tb_frame_decimator.sv
// Scoreboard bench for frame_decimator: stimulus queues expected start/done events,
// a negedge monitor pops and compares them against the DUT pulses.
module tb_frame_decimator;

`ifdef FRAME_DECIM_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif

   logic        iCLK = 1'b0;
   logic        iRST_N, iFVAL, iDVAL, iEN, iMODE;
   logic [3:0]  iSKIP;
   logic        oFrame_En, oDVAL, oFrame_Start, oFrame_Done, oBusy;
   logic [15:0] oCap_Cnt;

   frame_decimator #(.CNT_W(4)) dut (
      .iCLK         (iCLK),
      .iRST_N       (iRST_N),
      .iFVAL        (iFVAL),
      .iDVAL        (iDVAL),
      .iEN          (iEN),
      .iMODE        (iMODE),
      .iSKIP        (iSKIP),
      .oFrame_En    (oFrame_En),
      .oDVAL        (oDVAL),
      .oFrame_Start (oFrame_Start),
      .oFrame_Done  (oFrame_Done),
      .oBusy        (oBusy),
      .oCap_Cnt     (oCap_Cnt)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      bit is_done;
      int cyc;
      int pix;
   } ev_t;

   ev_t q[$];
   int  cyc = 0;
   int  d_pass = 0, d_tot = 0;
   int  m_pass = 0, m_tot = 0;
   int  pix_cnt = 0;
   int  stray = 0;
   int  exp_cap = 0;

   always @(posedge iCLK) cyc <= cyc + 1;

   // Monitor: every start/done pulse must match the head of the expectation queue.
   always @(negedge iCLK) begin
      ev_t e;
      if (oFrame_Start) pix_cnt = 0;
      if (oDVAL) begin
         pix_cnt = pix_cnt + 1;
         if (!oFrame_En) stray = stray + 1;
      end
      if (oFrame_Start || oFrame_Done) begin
         m_tot = m_tot + 1;
         if (q.size() == 0) begin
            $display("FAIL unexpected_event: start=%0d done=%0d at cycle %0d, none expected",
                     oFrame_Start, oFrame_Done, cyc);
         end else begin
            e = q.pop_front();
            if (oFrame_Done != e.is_done || oFrame_Start == e.is_done || cyc != e.cyc) begin
               $display("FAIL event_timing: got done=%0d at cycle %0d, expected done=%0d at cycle %0d",
                        oFrame_Done, cyc, e.is_done, e.cyc);
            end else if (oFrame_En != !e.is_done) begin
               $display("FAIL event_frame_en: got %0d expected %0d at cycle %0d",
                        oFrame_En, !e.is_done, cyc);
            end else if (e.is_done && pix_cnt != e.pix) begin
               $display("FAIL pixel_count: got %0d expected %0d at cycle %0d",
                        pix_cnt, e.pix, cyc);
            end else begin
               m_pass = m_pass + 1;
            end
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge iCLK);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      d_tot = d_tot + 1;
      if (act === exp) d_pass = d_pass + 1;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push_ev(input bit is_done, input int c, input int p);
      ev_t e;
      e.is_done = is_done;
      e.cyc     = c;
      e.pix     = p;
      q.push_back(e);
   endtask

   // One frame of len cycles with iDVAL high throughout, followed by gap low cycles.
   task automatic frame(input int len, input bit cap, input int gap);
      if (cap) begin
         push_ev(1'b0, cyc + 1, 0);
         push_ev(1'b1, cyc + len + 1, len);
         exp_cap = exp_cap + 1;
      end
      iFVAL = 1'b1;
      iDVAL = 1'b1;
      tick(len);
      iFVAL = 1'b0;
      iDVAL = 1'b0;
      tick(gap);
   endtask

   task automatic check_cap(input string name);
      check(name, {16'd0, oCap_Cnt}, Stats ? exp_cap : 0);
   endtask

   initial begin
      bit skip_pat [12];
      iRST_N = 1'b0;
      iFVAL  = 1'b0;
      iDVAL  = 1'b0;
      iEN    = 1'b0;
      iMODE  = 1'b0;
      iSKIP  = 4'd0;
      tick(3);
      check("rst_outputs", {oFrame_En, oDVAL, oFrame_Start, oFrame_Done, oBusy}, 0);
      check("rst_cap_cnt", {16'd0, oCap_Cnt}, 0);
      iRST_N = 1'b1;
      tick(2);
      check("idle_busy", {31'd0, oBusy}, 0);

      // Continuous, no skipping: every frame captured.
      iEN = 1'b1;
      tick(2);
      check("arm_busy", {31'd0, oBusy}, 1);
      frame(5, 1'b1, 3);
      frame(3, 1'b1, 2);
      frame(6, 1'b1, 4);
      frame(1, 1'b1, 3);
      check_cap("cap_after_4");

      // New skip value is picked up at the first capture's end, so frames 1, 5, 9 pass.
      iSKIP = 4'd3;
      for (int i = 0; i < 12; i++) skip_pat[i] = (i % 4 == 0);
      for (int i = 0; i < 12; i++) frame(3, skip_pat[i], 2);
      check_cap("cap_after_skip3");
      iEN = 1'b0;
      tick(2);
      check("disabled_busy", {31'd0, oBusy}, 0);

      // Enable raised mid-frame: that frame is ignored, the next one captured.
      iSKIP = 4'd0;
      iEN   = 1'b1;
      frame(6, 1'b0, 3);
      frame(4, 1'b1, 3);
      check_cap("cap_after_midframe_en");

      // Single-shot: one capture then HOLD until enable toggles.
      iMODE = 1'b1;
      frame(4, 1'b1, 2);
      for (int i = 0; i < 4; i++) frame(3, 1'b0, 2);
      check("hold_busy", {31'd0, oBusy}, 1);
      check_cap("cap_single_shot");
      iEN = 1'b0;
      tick(1);
      iEN = 1'b1;
      tick(2);
      frame(5, 1'b1, 2);
      check_cap("cap_second_shot");
      iEN = 1'b0;
      tick(1);
      iMODE = 1'b0;
      iEN   = 1'b1;
      tick(2);

      // Enable dropped mid-capture: the frame still completes.
      push_ev(1'b0, cyc + 1, 0);
      push_ev(1'b1, cyc + 7, 6);
      exp_cap = exp_cap + 1;
      iFVAL = 1'b1;
      iDVAL = 1'b1;
      tick(2);
      iEN = 1'b0;
      tick(4);
      check("en_drop_frame_en", {31'd0, oFrame_En}, 1);
      check("en_drop_busy_mid", {31'd0, oBusy}, 1);
      iFVAL = 1'b0;
      iDVAL = 1'b0;
      tick(1);
      check("en_drop_end", {30'd0, oFrame_En, oBusy}, 0);
      check_cap("cap_en_drop");

      // Reset mid-capture: outputs clear, interrupted frame never resumes.
      iEN = 1'b1;
      tick(2);
      push_ev(1'b0, cyc + 1, 0);
      iFVAL = 1'b1;
      iDVAL = 1'b1;
      tick(3);
      check("pre_rst_frame_en", {31'd0, oFrame_En}, 1);
      iRST_N = 1'b0;
      tick(1);
      check("midrst_outputs", {oFrame_En, oDVAL, oFrame_Start, oFrame_Done, oBusy}, 0);
      check("midrst_cap_cnt", {16'd0, oCap_Cnt}, 0);
      exp_cap = 0;
      iRST_N = 1'b1;
      tick(3);
      check("post_rst_no_en", {31'd0, oFrame_En}, 0);
      iFVAL = 1'b0;
      iDVAL = 1'b0;
      tick(3);

      // Back-to-back frames with a single idle cycle between them.
      frame(4, 1'b1, 1);
      frame(4, 1'b1, 3);
      check_cap("cap_back_to_back");

      tick(5);
      check("queue_drained", q.size(), 0);
      check("stray_dval", stray, 0);
      $display("%0d/%0d checks passed", d_pass + m_pass, d_tot + m_tot);
      $finish;
   end

endmodule
